// File: rtl/mem_scan_ctrl_if.sv
// Bus between the memory scan controller and its surroundings (CPU address, RAM, display).
// slave = the controller, master = the environment driving it.
interface mem_scan_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_enable;
    logic          i_step_pulse;
    logic          i_auto_mode;
    logic          i_dir;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_mem_rdata;
    logic [AW-1:0] o_madr;
    logic [AW+DW-1:0] o_hex;
    logic          o_rd_valid;
    logic          o_wrapped;
    logic          o_scan_active;

    modport slave (
        input  i_enable, i_step_pulse, i_auto_mode, i_dir, i_cpu_addr, i_mem_rdata,
        output o_madr, o_hex, o_rd_valid, o_wrapped, o_scan_active
    );

    modport master (
        output i_enable, i_step_pulse, i_auto_mode, i_dir, i_cpu_addr, i_mem_rdata,
        input  o_madr, o_hex, o_rd_valid, o_wrapped, o_scan_active
    );
endinterface

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: walks RAM addresses (manual/auto, up/down, modular stride) and captures {addr,data}.
// Advance in cycle N -> new madr in N+1, hex/rd_valid in N+RD_LAT+2; steps arriving outside HOLD are dropped.
module mem_scan_ctrl #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int DEPTH    = 256,
    parameter int STRIDE   = 1,
    parameter int RD_LAT   = 1,
    parameter int AUTO_DIV = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_scan_ctrl_if.slave bus
);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CW = $clog2(AUTO_DIV);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STRIDE_W = (AW+1)'(STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_scan_addr;
    logic [LW-1:0]    r_lat_cnt;
    logic [CW-1:0]    r_auto_cnt;
    logic [AW+DW-1:0] r_hex;
    logic             r_rd_valid;
    logic             r_wrapped;

    logic             w_tick;
    logic             w_advance;
    logic             w_capture;
    logic             w_scan_active;
    logic             w_wrap;
    logic [AW:0]      w_ext;
    logic [AW:0]      w_up;
    logic [AW-1:0]    w_next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Disable always wins; a capture already in flight still completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.i_enable) w_next = S_FETCH;
            S_FETCH: begin
                if (!bus.i_enable)                      w_next = S_IDLE;
                else if (r_lat_cnt == LW'(RD_LAT - 1))  w_next = S_CAPTURE;
            end
            S_CAPTURE: w_next = bus.i_enable ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (!bus.i_enable)  w_next = S_IDLE;
                else if (w_advance) w_next = S_FETCH;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_scan_active = (r_state != S_IDLE);
        w_capture     = (r_state == S_CAPTURE);
        w_tick        = bus.i_auto_mode && (r_auto_cnt == CW'(AUTO_DIV - 1));
        w_advance     = (r_state == S_HOLD) && bus.i_enable && (bus.i_step_pulse || w_tick);
    end

    // One extra bit keeps the modular arithmetic free of AW overflow for any DEPTH.
    always_comb begin
        w_ext  = {1'b0, r_scan_addr};
        w_up   = '0;
        w_wrap = 1'b0;
        if (!bus.i_dir) begin
            w_up = w_ext + STRIDE_W;
            if (w_up >= DEPTH_W) begin
                w_up   = w_up - DEPTH_W;
                w_wrap = 1'b1;
            end
        end else if (w_ext < STRIDE_W) begin
            w_up   = w_ext + DEPTH_W - STRIDE_W;
            w_wrap = 1'b1;
        end else begin
            w_up = w_ext - STRIDE_W;
        end
        w_next_addr = w_up[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_addr <= '0;
            r_lat_cnt   <= '0;
            r_auto_cnt  <= '0;
            r_hex       <= '0;
            r_rd_valid  <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            r_rd_valid <= w_capture;
            r_wrapped  <= w_advance && w_wrap;
            if (w_advance) r_scan_addr <= w_next_addr;
            if (r_state == S_FETCH) r_lat_cnt <= r_lat_cnt + LW'(1);
            else                    r_lat_cnt <= '0;
            if ((r_state == S_HOLD) && bus.i_auto_mode && !w_advance)
                r_auto_cnt <= r_auto_cnt + CW'(1);
            else
                r_auto_cnt <= '0;
            if (r_state == S_IDLE)  r_hex <= {bus.i_cpu_addr, bus.i_mem_rdata};
            else if (w_capture)     r_hex <= {r_scan_addr, bus.i_mem_rdata};
        end
    end

    assign bus.o_madr        = w_scan_active ? r_scan_addr : bus.i_cpu_addr;
    assign bus.o_hex         = r_hex;
    assign bus.o_rd_valid    = r_rd_valid;
    assign bus.o_wrapped     = r_wrapped;
    assign bus.o_scan_active = w_scan_active;
endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: three builds (default, DEPTH=10/STRIDE=3, RD_LAT=3) share most stimulus;
// expected captures and wrap pulses are queued at stimulus time and matched on rd_valid/wrapped.
module tb_mem_scan_ctrl;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int AUTO_DIV = 4;

    typedef struct packed {
        logic [31:0] hex;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          en, stp, dir, auto0;
    logic [AW-1:0] cpu;

    mem_scan_ctrl_if #(.AW(AW), .DW(DW)) b0 ();
    mem_scan_ctrl_if #(.AW(AW), .DW(DW)) b1 ();
    mem_scan_ctrl_if #(.AW(AW), .DW(DW)) b2 ();

    mem_scan_ctrl #(.AW(AW), .DW(DW), .DEPTH(256), .STRIDE(1), .RD_LAT(1), .AUTO_DIV(AUTO_DIV))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    mem_scan_ctrl #(.AW(AW), .DW(DW), .DEPTH(10), .STRIDE(3), .RD_LAT(1), .AUTO_DIV(AUTO_DIV))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mem_scan_ctrl #(.AW(AW), .DW(DW), .DEPTH(256), .STRIDE(1), .RD_LAT(3), .AUTO_DIV(AUTO_DIV))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    assign b0.i_enable = en;   assign b1.i_enable = en;   assign b2.i_enable = en;
    assign b0.i_step_pulse = stp; assign b1.i_step_pulse = stp; assign b2.i_step_pulse = stp;
    assign b0.i_dir = dir;     assign b1.i_dir = dir;     assign b2.i_dir = dir;
    assign b0.i_cpu_addr = cpu; assign b1.i_cpu_addr = cpu; assign b2.i_cpu_addr = cpu;
    assign b0.i_auto_mode = auto0;
    assign b1.i_auto_mode = 1'b0;
    assign b2.i_auto_mode = 1'b0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // RAM models: 1-cycle for u0/u1, 3-cycle pipeline for u2
    logic [15:0] p1, p2;
    always @(posedge clk) begin
        b0.i_mem_rdata <= memf(b0.o_madr);
        b1.i_mem_rdata <= memf(b1.o_madr);
        p1 <= memf(b2.o_madr);
        p2 <= p1;
        b2.i_mem_rdata <= p2;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int depth_a[3]  = '{256, 10, 256};
    int stride_a[3] = '{1, 3, 1};
    int lat_a[3]    = '{1, 1, 3};
    int exp_addr[3] = '{0, 0, 0};

    exp_t q0[$], q1[$], q2[$];
    int   w0[$], w1[$], w2[$];

    task automatic push_cap(input int d, input int a, input int c);
        exp_t e;
        e.hex = {a[15:0], memf(a[15:0])};
        e.cyc = c;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_wrap(input int d, input int c);
        case (d)
            0: w0.push_back(c);
            1: w1.push_back(c);
            default: w2.push_back(c);
        endcase
    endtask

    // Model one advance of build d in cycle c; optionally expect its capture.
    task automatic adv(input int d, input int c, input logic dr, input bit cap);
        int a, s, dp, na;
        bit wr;
        a = exp_addr[d]; s = stride_a[d]; dp = depth_a[d];
        wr = 1'b0;
        if (!dr) begin
            if (a + s >= dp) begin na = a + s - dp; wr = 1'b1; end
            else na = a + s;
        end else begin
            if (a < s) begin na = a + dp - s; wr = 1'b1; end
            else na = a - s;
        end
        exp_addr[d] = na;
        if (wr) push_wrap(d, c + 1);
        if (cap) push_cap(d, na, c + lat_a[d] + 2);
    endtask

    function automatic logic [15:0] madr_of(input int d);
        case (d)
            0: return b0.o_madr;
            1: return b1.o_madr;
            default: return b2.o_madr;
        endcase
    endfunction

    function automatic logic sa_of(input int d);
        case (d)
            0: return b0.o_scan_active;
            1: return b1.o_scan_active;
            default: return b2.o_scan_active;
        endcase
    endfunction

    task automatic mon(input int d, input logic rv, input logic [31:0] hx, input logic wr);
        exp_t e;
        int   wc;
        bit   got;
        if (rv) begin
            got = 1'b0;
            case (d)
                0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) check($sformatf("u%0d_spurious_rd_valid@%0d", d, cyc), 1, 0);
            else begin
                check($sformatf("u%0d_hex", d), hx, e.hex);
                check($sformatf("u%0d_capture_cycle", d), cyc, e.cyc);
            end
        end
        if (wr) begin
            got = 1'b0;
            case (d)
                0: if (w0.size() > 0) begin wc = w0.pop_front(); got = 1'b1; end
                1: if (w1.size() > 0) begin wc = w1.pop_front(); got = 1'b1; end
                default: if (w2.size() > 0) begin wc = w2.pop_front(); got = 1'b1; end
            endcase
            if (!got) check($sformatf("u%0d_spurious_wrapped@%0d", d, cyc), 1, 0);
            else check($sformatf("u%0d_wrapped_cycle", d), cyc, wc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, b0.o_rd_valid, b0.o_hex, b0.o_wrapped);
            mon(1, b1.o_rd_valid, b1.o_hex, b1.o_wrapped);
            mon(2, b2.o_rd_valid, b2.o_hex, b2.o_wrapped);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single step pulse to all builds (all in HOLD), then check the new scan address on madr.
    task automatic do_step(input logic dr);
        int c;
        c = cyc;
        dir = dr; stp = 1'b1;
        for (int d = 0; d < 3; d++) adv(d, c, dr, 1'b1);
        tick(1);
        stp = 1'b0;
        for (int d = 0; d < 3; d++)
            check($sformatf("u%0d_madr_after_step", d), madr_of(d), exp_addr[d]);
        tick(8);
    endtask

    initial begin
        int c, t0;
        en = 1'b0; stp = 1'b0; dir = 1'b0; auto0 = 1'b0; cpu = 16'h0012;
        tick(3);
        check("rst_hex", b0.o_hex, 0);
        check("rst_hex_u2", b2.o_hex, 0);
        check("rst_scan_active", b0.o_scan_active, 0);
        check("rst_rd_valid", b0.o_rd_valid, 0);
        check("rst_wrapped", b1.o_wrapped, 0);
        check("rst_madr", b0.o_madr, cpu);
        rst_n = 1'b1;
        tick(5);
        check("idle_hex_u0", b0.o_hex, {cpu, memf(cpu)});
        check("idle_hex_u2", b2.o_hex, {cpu, memf(cpu)});

        // Reset asserted while fetching
        en = 1'b1;
        tick(1);
        check("fetch_scan_active", b2.o_scan_active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hex", b2.o_hex, 0);
        check("midrst_scan_active", b2.o_scan_active, 0);
        check("midrst_madr", b2.o_madr, cpu);
        en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        // Manual ascending scan from address 0
        cpu = 16'h0777;
        c = cyc;
        en = 1'b1;
        for (int d = 0; d < 3; d++) push_cap(d, exp_addr[d], c + lat_a[d] + 2);
        tick(1);
        check("first_madr", b0.o_madr, 0);
        tick(8);
        for (int k = 0; k < 4; k++) do_step(1'b0);
        do_step(1'b1);

        // Step still high during FETCH must not cause a second advance
        c = cyc;
        dir = 1'b0; stp = 1'b1;
        for (int d = 0; d < 3; d++) adv(d, c, 1'b0, 1'b1);
        tick(2);
        stp = 1'b0;
        tick(8);

        // Advance then disable during FETCH: no capture, resume at the advanced address
        c = cyc;
        stp = 1'b1;
        for (int d = 0; d < 3; d++) adv(d, c, 1'b0, 1'b0);
        tick(1);
        stp = 1'b0; en = 1'b0;
        tick(4);
        for (int d = 0; d < 3; d++) check($sformatf("u%0d_abort_idle", d), sa_of(d), 0);
        c = cyc;
        en = 1'b1;
        for (int d = 0; d < 3; d++) push_cap(d, exp_addr[d], c + lat_a[d] + 2);
        tick(10);

        // Auto mode on u0: tick after AUTO_DIV hold cycles; a step on the 4th tick merges with it
        t0 = cyc;
        auto0 = 1'b1;
        for (int k = 0; k < 4; k++)
            adv(0, t0 + AUTO_DIV - 1 + k * (AUTO_DIV + lat_a[0] + 1), 1'b0, 1'b1);
        tick(AUTO_DIV - 1 + 3 * (AUTO_DIV + lat_a[0] + 1));
        stp = 1'b1;
        for (int d = 1; d < 3; d++) adv(d, cyc, 1'b0, 1'b1);
        tick(1);
        stp = 1'b0;
        tick(3);
        auto0 = 1'b0;
        tick(15);

        check("sb_caps_left", q0.size() + q1.size() + q2.size(), 0);
        check("sb_wraps_left", w0.size() + w1.size() + w2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
